serial_tx_piso: RTL

//   Parallel-in, serial-out transmitter that drives a 1-bit data line and frame strobe.

---
 rtl/serial_tx_piso_if.sv | 12 +
 rtl/serial_tx_piso.sv | 110 +++++++++++
 2 files changed

// File: rtl/serial_tx_piso_if.sv
// Word handshake between an upstream producer and the serial transmitter.
// The producer (master) offers data_in/valid_in; the transmitter (slave) answers with ready_out.
interface serial_tx_piso_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/serial_tx_piso.sv
// Parallel-in serial-out transmitter: one word per handshake, one bit per clk on sd_out.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit after the payload.
module serial_tx_piso #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  serial_tx_piso_if.slave    up,
  output logic               sd_out,
  output logic               sd_frame,
  output logic               busy,
  output logic               done
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] NBITS_C = CW'(NBITS);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sd_q, sd_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
  logic [NBITS-1:0] frameWord;
  logic             accept;

  // Parity always trails the payload, so its position depends on the shift direction.
`ifdef SERIAL_TX_PARITY_EN
  assign frameWord = LSB_FIRST ? {^up.data_in, up.data_in} : {up.data_in, ^up.data_in};
`else
  assign frameWord = up.data_in;
`endif

  assign up.ready_out = (state_q == IDLE) & ~reset;
  assign accept       = up.valid_in & up.ready_out;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sd_d    = sd_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        sd_d    = 1'b0;
        frame_d = 1'b0;
        if (accept) begin
          state_d = SHIFT;
          frame_d = 1'b1;
          cnt_d   = CW'(1);
          if (LSB_FIRST) begin
            sd_d    = frameWord[0];
            shreg_d = frameWord >> 1;
          end else begin
            sd_d    = frameWord[NBITS-1];
            shreg_d = frameWord << 1;
          end
        end
      end
      SHIFT: begin
        // cnt_q counts bits already shown; the edge after the last one closes the frame.
        if (cnt_q == NBITS_C) begin
          state_d = IDLE;
          sd_d    = 1'b0;
          frame_d = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          sd_d    = LSB_FIRST ? shreg_q[0] : shreg_q[NBITS-1];
          shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sd_q    <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sd_q    <= sd_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  assign sd_out   = sd_q;
  assign sd_frame = frame_q;
  assign done     = done_q;
  assign busy     = (state_q == SHIFT);

endmodule
